// File: rtl/bram_lsu_bridge_if.sv
// -----------------------------------------------------------------------------
// bram_lsu_bridge_if
// Bundles the core's data-memory request/response channel and the block-RAM
// port that the load/store bridge sits between.
//
//   req_*      core -> bridge request (valid/ready)
//   resp_*     bridge -> core response (valid/ready, data, error)
//   bram_*     bridge <-> byte-write-enable RAM (address, write data, byte
//              write enables, read data one cycle after the address)
//
// Modports:
//   slave  - the bridge itself
//   master - the environment (core + RAM), e.g. a testbench
// -----------------------------------------------------------------------------
interface bram_lsu_bridge_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_din;
  logic [3:0]            bram_we;
  logic [31:0]           bram_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, bram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bram_addr, bram_din, bram_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, bram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bram_addr, bram_din, bram_we
  );
endinterface

// File: rtl/bram_lsu_bridge.sv
// -----------------------------------------------------------------------------
// bram_lsu_bridge
// Load/store bridge between the core's data-memory request channel and a
// byte-write-enable block RAM with one cycle of read latency.
//
// Stores: byte address/size/data become the RAM word address, lane-replicated
// write data and a 4-bit byte-write mask, all combinational in the accept
// cycle; a zero-data response follows one cycle later.
// Loads: the RAM is addressed in the accept cycle, the addressed lane is
// extracted from the read data the next cycle, sign/zero extended and held
// on the response channel until the consumer takes it.
// Misaligned or illegal-size requests never touch the RAM and answer with
// resp_err=1, resp_rdata=0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bram_lsu_bridge_if.slave (request, response and RAM signals)
// -----------------------------------------------------------------------------
module bram_lsu_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_lsu_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Request is unusable: illegal size, or not naturally aligned.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-write mask for a legal store.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << off;
      SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Right-aligned store data replicated across every lane it could land in,
  // so the byte mask alone selects the destination.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] dout, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] res;
    lane_b = dout[{off, 3'b000} +: 8];
    lane_h = dout[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = uns ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: res = uns ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: res = dout;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic        ready_s;
  logic        accept_s;
  logic        resp_valid_s;
  logic [3:0]  we_s;
  logic        illegal_s;
  logic        unused_addr_bits_s;

  assign illegal_s = req_illegal(bus.req_size, bus.req_addr[1:0]);

  // Bits above the RAM's reach are dropped on purpose: the address space aliases.
  assign unused_addr_bits_s = ^bus.req_addr[31:ADDR_WIDTH+2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (!illegal_s && !bus.req_we) begin
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs. req_ready is gated by rst_n so nothing is accepted
  // (and nothing written) while reset is held.
  always_comb begin
    ready_s      = 1'b0;
    resp_valid_s = 1'b0;
    case (state_q)
      ST_IDLE:    ready_s      = rst_n;
      ST_RD_WAIT: ready_s      = 1'b0;
      ST_RESP:    resp_valid_s = 1'b1;
      default:    ready_s      = 1'b0;
    endcase
    accept_s = bus.req_valid & ready_s;
    if (accept_s && bus.req_we && !illegal_s) begin
      we_s = store_mask(bus.req_size, bus.req_addr[1:0]);
    end else begin
      we_s = 4'b0000;
    end
  end

  // Response / load-context next values.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    if (accept_s) begin
      if (illegal_s) begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b1;
      end else if (bus.req_we) begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b0;
      end else begin
        off_d  = bus.req_addr[1:0];
        size_d = bus.req_size;
        uns_d  = bus.req_unsigned;
      end
    end else if (state_q == ST_RD_WAIT) begin
      // RAM read data for the accepted address is valid in this cycle.
      rdata_d = load_extract(bus.bram_dout, off_q, size_q, uns_q);
      err_d   = 1'b0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response / load-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.bram_we    = we_s;
  assign bus.bram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
  assign bus.bram_din   = store_data(bus.req_size, bus.req_wdata);

endmodule
